// File: rtl/dcache_req_queue.sv
// In-order request queue between the CPU load/store port and the data cache.
// Holds the oldest request on the pipe_req bus until retired; one response per request.

package dcache_req_queue_pkg;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memory_operation_size_e;
  typedef enum logic [1:0] {LOAD = 2'd0, STORE = 2'd1, CLFLUSH = 2'd2} memory_operation_e;
endpackage

module dcache_req_queue
  import dcache_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned OFS_SIZE = 5,
  parameter int unsigned SET_SIZE = 3,
  parameter int unsigned TAG_SIZE = 24,
  parameter int unsigned XLEN     = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cpu_req_valid_i,
  output logic                  cpu_req_ready_o,
  input  logic [XLEN-1:0]       cpu_req_address_i,
  input  memory_operation_size_e cpu_req_size_i,
  input  memory_operation_e     cpu_req_type_i,
  input  logic [XLEN-1:0]       cpu_word_to_store_i,
  output logic [OFS_SIZE-1:0]   pipe_req_ofs_o,
  output logic [SET_SIZE-1:0]   pipe_req_set_o,
  output logic [TAG_SIZE-1:0]   pipe_req_tag_o,
  output memory_operation_size_e pipe_req_size_o,
  output memory_operation_e     pipe_req_type_o,
  output logic [XLEN-1:0]       pipe_word_to_store_o,
  output logic                  pipe_req_valid_o,
  input  logic                  req_done_i,
  input  logic [XLEN-1:0]       pipe_fetched_word_i,
  output logic                  cpu_rsp_valid_o,
  output logic [XLEN-1:0]       cpu_rsp_data_o,
  output logic                  cpu_rsp_error_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TAG_SIZE-1:0]    tag;
    logic [SET_SIZE-1:0]    set;
    logic [OFS_SIZE-1:0]    ofs;
    memory_operation_size_e size;
    memory_operation_e      op;
    logic [XLEN-1:0]        word;
    logic                   err;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            head;
  entry_t            new_entry;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_error_q, rsp_error_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              enq, deq, not_empty, misaligned;

  assign head      = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);

  assign cpu_req_ready_o      = (count_q != CNT_W'(DEPTH));
  assign pipe_req_valid_o     = not_empty && !head.err;
  assign pipe_req_tag_o       = head.tag;
  assign pipe_req_set_o       = head.set;
  assign pipe_req_ofs_o       = head.ofs;
  assign pipe_req_size_o      = head.size;
  assign pipe_req_type_o      = head.op;
  assign pipe_word_to_store_o = head.word;
  assign cpu_rsp_valid_o      = rsp_valid_q;
  assign cpu_rsp_error_o      = rsp_error_q;
  assign cpu_rsp_data_o       = rsp_data_q;

  // Next-state: entry build, pointer/count update and response register.
  always_comb begin
    misaligned  = 1'b0;
    new_entry   = '0;
    enq         = 1'b0;
    deq         = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_data_d  = '0;

    // Cache-line flushes ignore alignment.
    if (cpu_req_type_i != CLFLUSH) begin
      misaligned = ((cpu_req_size_i == HALF) && cpu_req_address_i[0]) ||
                   ((cpu_req_size_i == WORD) && (cpu_req_address_i[1:0] != 2'b00));
    end

    new_entry.tag  = cpu_req_address_i[XLEN-1 -: TAG_SIZE];
    new_entry.set  = cpu_req_address_i[OFS_SIZE +: SET_SIZE];
    new_entry.ofs  = cpu_req_address_i[OFS_SIZE-1:0];
    new_entry.size = cpu_req_size_i;
    new_entry.op   = cpu_req_type_i;
    new_entry.word = cpu_word_to_store_i;
    new_entry.err  = misaligned;

    enq = cpu_req_valid_i && cpu_req_ready_o;
    // Error heads retire on their own; normal heads wait for the controller.
    deq = not_empty && (head.err || req_done_i);

    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

    if (deq) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = head.err;
      if (!head.err && (head.op == LOAD)) rsp_data_d = pipe_fetched_word_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= new_entry;
  end

endmodule

// File: tb/tb_dcache_req_queue.sv
// Self-checking bench for dcache_req_queue: directed scenarios plus a randomized run
// against a queue-based reference model.

module tb_dcache_req_queue;
  import dcache_req_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                   clk_i = 1'b0;
  logic                   reset_i = 1'b1;
  logic                   cpu_req_valid_i = 1'b0;
  logic                   cpu_req_ready_o;
  logic [31:0]            cpu_req_address_i = '0;
  memory_operation_size_e cpu_req_size_i = WORD;
  memory_operation_e      cpu_req_type_i = LOAD;
  logic [31:0]            cpu_word_to_store_i = '0;
  logic [4:0]             pipe_req_ofs_o;
  logic [2:0]             pipe_req_set_o;
  logic [23:0]            pipe_req_tag_o;
  memory_operation_size_e pipe_req_size_o;
  memory_operation_e      pipe_req_type_o;
  logic [31:0]            pipe_word_to_store_o;
  logic                   pipe_req_valid_o;
  logic                   req_done_i = 1'b0;
  logic [31:0]            pipe_fetched_word_i = '0;
  logic                   cpu_rsp_valid_o;
  logic [31:0]            cpu_rsp_data_o;
  logic                   cpu_rsp_error_o;

  int checks = 0;
  int failures = 0;
  int proto_notes = 0;

  dcache_req_queue #(.DEPTH(DEPTH), .OFS_SIZE(5), .SET_SIZE(3), .TAG_SIZE(24), .XLEN(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cpu_req_valid_i(cpu_req_valid_i), .cpu_req_ready_o(cpu_req_ready_o),
    .cpu_req_address_i(cpu_req_address_i), .cpu_req_size_i(cpu_req_size_i),
    .cpu_req_type_i(cpu_req_type_i), .cpu_word_to_store_i(cpu_word_to_store_i),
    .pipe_req_ofs_o(pipe_req_ofs_o), .pipe_req_set_o(pipe_req_set_o),
    .pipe_req_tag_o(pipe_req_tag_o), .pipe_req_size_o(pipe_req_size_o),
    .pipe_req_type_o(pipe_req_type_o), .pipe_word_to_store_o(pipe_word_to_store_o),
    .pipe_req_valid_o(pipe_req_valid_o), .req_done_i(req_done_i),
    .pipe_fetched_word_i(pipe_fetched_word_i), .cpu_rsp_valid_o(cpu_rsp_valid_o),
    .cpu_rsp_data_o(cpu_rsp_data_o), .cpu_rsp_error_o(cpu_rsp_error_o)
  );

  always #5 clk_i = ~clk_i;

  // Protocol monitor: req_done without a valid head is a controller violation.
  always @(negedge clk_i) begin
    if (!reset_i && req_done_i && !pipe_req_valid_o) begin
      proto_notes++;
      $display("note: protocol violation, req_done with no valid head at %0t", $time);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    cpu_req_valid_i = 1'b0;
    req_done_i      = 1'b0;
  endtask

  task automatic set_req(input logic [31:0] a, input memory_operation_size_e s,
                         input memory_operation_e t, input logic [31:0] w);
    cpu_req_valid_i     = 1'b1;
    cpu_req_address_i   = a;
    cpu_req_size_i      = s;
    cpu_req_type_i      = t;
    cpu_word_to_store_i = w;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    idle();
    @(negedge clk_i);
    checks++; if ({cpu_req_ready_o, pipe_req_valid_o, cpu_rsp_valid_o, cpu_rsp_error_o} !== 4'b1000) begin
      failures++; $display("FAIL reset_flags: got %b want 1000", {cpu_req_ready_o, pipe_req_valid_o, cpu_rsp_valid_o, cpu_rsp_error_o}); end
    checks++; if (cpu_rsp_data_o !== 32'h0) begin
      failures++; $display("FAIL reset_data: got %h want 0", cpu_rsp_data_o); end
    reset_i = 1'b0;
    @(negedge clk_i);
    checks++; if ({cpu_req_ready_o, pipe_req_valid_o, cpu_rsp_valid_o} !== 3'b100) begin
      failures++; $display("FAIL post_reset_flags: got %b want 100", {cpu_req_ready_o, pipe_req_valid_o, cpu_rsp_valid_o}); end
  endtask

  task automatic test_single_load();
    do_reset();
    set_req(32'h0000_1234, WORD, LOAD, 32'h0);
    tick();
    idle();
    @(negedge clk_i);
    checks++; if ({pipe_req_tag_o, pipe_req_set_o, pipe_req_ofs_o} !== {24'h000012, 3'd1, 5'h14}) begin
      failures++; $display("FAIL load_split: got tag=%h set=%h ofs=%h want 000012/1/14", pipe_req_tag_o, pipe_req_set_o, pipe_req_ofs_o); end
    checks++; if (pipe_req_valid_o !== 1'b1 || pipe_req_type_o !== LOAD) begin
      failures++; $display("FAIL load_head: got valid=%b type=%0d want 1/LOAD", pipe_req_valid_o, pipe_req_type_o); end
    req_done_i = 1'b1;
    pipe_fetched_word_i = 32'hDEAD_BEEF;
    tick();
    req_done_i = 1'b0;
    @(negedge clk_i);
    checks++; if ({cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o} !== {2'b10, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL load_rsp: got v=%b e=%b d=%h want 1/0/deadbeef", cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o); end
    checks++; if (pipe_req_valid_o !== 1'b0) begin
      failures++; $display("FAIL load_drained: got pipe_valid=%b want 0", pipe_req_valid_o); end
    tick();
    @(negedge clk_i);
    checks++; if (cpu_rsp_valid_o !== 1'b0) begin
      failures++; $display("FAIL load_pulse: got rsp_valid=%b want 0", cpu_rsp_valid_o); end
  endtask

  task automatic test_fill_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(32'h200 + 32'(4 * i), WORD, STORE, 32'hA0 + 32'(i));
      tick();
      idle();
      @(negedge clk_i);
      checks++; if (cpu_req_ready_o !== (i < 3)) begin
        failures++; $display("FAIL full_ready_%0d: got %b want %b", i, cpu_req_ready_o, (i < 3)); end
    end
    // Offered while full: must be dropped.
    set_req(32'h300, WORD, STORE, 32'hFF);
    tick();
    idle();
    @(negedge clk_i);
    checks++; if (cpu_req_ready_o !== 1'b0) begin
      failures++; $display("FAIL full_hold: got ready=%b want 0", cpu_req_ready_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (pipe_req_valid_o !== 1'b1 || pipe_word_to_store_o !== 32'hA0 + 32'(i)) begin
        failures++; $display("FAIL full_order_%0d: got v=%b word=%h want 1/%h", i, pipe_req_valid_o, pipe_word_to_store_o, 32'hA0 + 32'(i)); end
      req_done_i = 1'b1;
      pipe_fetched_word_i = 32'h1234_5678;
      tick();
      req_done_i = 1'b0;
      @(negedge clk_i);
      checks++; if ({cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o} !== {2'b10, 32'h0}) begin
        failures++; $display("FAIL full_rsp_%0d: got v=%b e=%b d=%h want 1/0/0", i, cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o); end
      if (i == 0) begin
        checks++; if (cpu_req_ready_o !== 1'b1) begin
          failures++; $display("FAIL full_ready_rise: got %b want 1", cpu_req_ready_o); end
      end
    end
    checks++; if (pipe_req_valid_o !== 1'b0) begin
      failures++; $display("FAIL full_dropped: got pipe_valid=%b want 0", pipe_req_valid_o); end
  endtask

  task automatic test_misaligned();
    do_reset();
    set_req(32'h100, WORD, LOAD, 32'h0);  tick();
    set_req(32'h101, HALF, STORE, 32'h5); tick();
    set_req(32'h103, BYTE, LOAD, 32'h0);  tick();
    idle();
    @(negedge clk_i);
    checks++; if (pipe_req_valid_o !== 1'b1 || pipe_req_ofs_o !== 5'h0) begin
      failures++; $display("FAIL mis_head0: got v=%b ofs=%h want 1/0", pipe_req_valid_o, pipe_req_ofs_o); end
    req_done_i = 1'b1;
    pipe_fetched_word_i = 32'h1111_1111;
    tick();
    req_done_i = 1'b0;
    @(negedge clk_i);
    checks++; if ({cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o} !== {2'b10, 32'h1111_1111}) begin
      failures++; $display("FAIL mis_rsp0: got v=%b e=%b d=%h want 1/0/11111111", cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o); end
    checks++; if (pipe_req_valid_o !== 1'b0) begin
      failures++; $display("FAIL mis_err_hidden: got pipe_valid=%b want 0", pipe_req_valid_o); end
    tick();
    @(negedge clk_i);
    checks++; if ({cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o} !== {2'b11, 32'h0}) begin
      failures++; $display("FAIL mis_rsp1: got v=%b e=%b d=%h want 1/1/0", cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o); end
    checks++; if (pipe_req_valid_o !== 1'b1 || pipe_req_ofs_o !== 5'h3 || pipe_req_size_o !== BYTE) begin
      failures++; $display("FAIL mis_head2: got v=%b ofs=%h size=%0d want 1/3/BYTE", pipe_req_valid_o, pipe_req_ofs_o, pipe_req_size_o); end
    req_done_i = 1'b1;
    pipe_fetched_word_i = 32'h2222_2222;
    tick();
    req_done_i = 1'b0;
    @(negedge clk_i);
    checks++; if ({cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o} !== {2'b10, 32'h2222_2222}) begin
      failures++; $display("FAIL mis_rsp2: got v=%b e=%b d=%h want 1/0/22222222", cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o); end
  endtask

  task automatic test_wrap_around();
    do_reset();
    set_req(32'd64, WORD, LOAD, 32'd1);
    tick();
    @(negedge clk_i);
    checks++; if (pipe_req_valid_o !== 1'b1 || pipe_word_to_store_o !== 32'd1) begin
      failures++; $display("FAIL wrap_first: got v=%b word=%0d want 1/1", pipe_req_valid_o, pipe_word_to_store_o); end
    for (int k = 2; k <= 10; k++) begin
      set_req(32'(64 * k), WORD, LOAD, 32'(k));
      req_done_i = 1'b1;
      pipe_fetched_word_i = 32'(k - 1);
      tick();
      @(negedge clk_i);
      checks++; if (cpu_rsp_valid_o !== 1'b1 || cpu_rsp_data_o !== 32'(k - 1)) begin
        failures++; $display("FAIL wrap_rsp_%0d: got v=%b d=%0d want 1/%0d", k - 1, cpu_rsp_valid_o, cpu_rsp_data_o, k - 1); end
      checks++; if (pipe_word_to_store_o !== 32'(k) || cpu_req_ready_o !== 1'b1 || pipe_req_valid_o !== 1'b1) begin
        failures++; $display("FAIL wrap_head_%0d: got word=%0d ready=%b v=%b want %0d/1/1", k, pipe_word_to_store_o, cpu_req_ready_o, pipe_req_valid_o, k); end
    end
    cpu_req_valid_i = 1'b0;
    pipe_fetched_word_i = 32'd10;
    tick();
    req_done_i = 1'b0;
    @(negedge clk_i);
    checks++; if (cpu_rsp_valid_o !== 1'b1 || cpu_rsp_data_o !== 32'd10 || pipe_req_valid_o !== 1'b0) begin
      failures++; $display("FAIL wrap_last: got v=%b d=%0d pv=%b want 1/10/0", cpu_rsp_valid_o, cpu_rsp_data_o, pipe_req_valid_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(32'h1000 + 32'(4 * i), WORD, LOAD, 32'h0);
      tick();
    end
    idle();
    @(negedge clk_i);
    req_done_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pipe_fetched_word_i = 32'h100 + 32'(i);
      tick();
      if (i == 3) req_done_i = 1'b0;
      @(negedge clk_i);
      checks++; if (cpu_rsp_valid_o !== 1'b1 || cpu_rsp_data_o !== 32'h100 + 32'(i)) begin
        failures++; $display("FAIL b2b_rsp_%0d: got v=%b d=%h want 1/%h", i, cpu_rsp_valid_o, cpu_rsp_data_o, 32'h100 + 32'(i)); end
    end
    tick();
    @(negedge clk_i);
    checks++; if (cpu_rsp_valid_o !== 1'b0 || pipe_req_valid_o !== 1'b0) begin
      failures++; $display("FAIL b2b_end: got rv=%b pv=%b want 0/0", cpu_rsp_valid_o, pipe_req_valid_o); end
  endtask

  task automatic test_ignored_done();
    do_reset();
    req_done_i = 1'b1;
    tick();
    @(negedge clk_i);
    checks++; if (cpu_rsp_valid_o !== 1'b0) begin
      failures++; $display("FAIL ign_empty: got rsp_valid=%b want 0", cpu_rsp_valid_o); end
    set_req(32'h2, WORD, LOAD, 32'h0);
    tick();
    cpu_req_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (pipe_req_valid_o !== 1'b0 || cpu_rsp_valid_o !== 1'b0) begin
      failures++; $display("FAIL ign_errhead: got pv=%b rv=%b want 0/0", pipe_req_valid_o, cpu_rsp_valid_o); end
    tick();
    @(negedge clk_i);
    checks++; if ({cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o} !== {2'b11, 32'h0}) begin
      failures++; $display("FAIL ign_errrsp: got v=%b e=%b d=%h want 1/1/0", cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o); end
    tick();
    req_done_i = 1'b0;
    @(negedge clk_i);
    checks++; if (cpu_rsp_valid_o !== 1'b0) begin
      failures++; $display("FAIL ign_single: got rsp_valid=%b want 0", cpu_rsp_valid_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(32'h40 * 32'(i + 1), WORD, LOAD, 32'h0);
      tick();
    end
    idle();
    @(negedge clk_i);
    req_done_i = 1'b1;
    pipe_fetched_word_i = 32'h55;
    tick();
    req_done_i = 1'b0;
    checks++; if (cpu_rsp_valid_o !== 1'b1) begin
      failures++; $display("FAIL rmid_pre: got rsp_valid=%b want 1", cpu_rsp_valid_o); end
    #2;
    reset_i = 1'b1;
    #1;
    checks++; if ({cpu_req_ready_o, pipe_req_valid_o, cpu_rsp_valid_o, cpu_rsp_error_o} !== 4'b1000 || cpu_rsp_data_o !== 32'h0) begin
      failures++; $display("FAIL rmid_async: got flags=%b d=%h want 1000/0", {cpu_req_ready_o, pipe_req_valid_o, cpu_rsp_valid_o, cpu_rsp_error_o}, cpu_rsp_data_o); end
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++; if (cpu_rsp_valid_o !== 1'b0 || pipe_req_valid_o !== 1'b0 || cpu_req_ready_o !== 1'b1) begin
        failures++; $display("FAIL rmid_after_%0d: got rv=%b pv=%b ready=%b want 0/0/1", i, cpu_rsp_valid_o, pipe_req_valid_o, cpu_req_ready_o); end
    end
  endtask

  task automatic test_clflush();
    do_reset();
    set_req(32'h0000_0003, WORD, CLFLUSH, 32'h77);
    tick();
    idle();
    @(negedge clk_i);
    checks++; if (pipe_req_valid_o !== 1'b1 || pipe_req_type_o !== CLFLUSH || pipe_req_ofs_o !== 5'h3) begin
      failures++; $display("FAIL clf_head: got v=%b type=%0d ofs=%h want 1/CLFLUSH/3", pipe_req_valid_o, pipe_req_type_o, pipe_req_ofs_o); end
    req_done_i = 1'b1;
    pipe_fetched_word_i = 32'hCAFE_F00D;
    tick();
    req_done_i = 1'b0;
    @(negedge clk_i);
    checks++; if ({cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o} !== {2'b10, 32'h0}) begin
      failures++; $display("FAIL clf_rsp: got v=%b e=%b d=%h want 1/0/0", cpu_rsp_valid_o, cpu_rsp_error_o, cpu_rsp_data_o); end
  endtask

  typedef struct {
    logic [31:0]            addr;
    memory_operation_size_e size;
    memory_operation_e      op;
    logic [31:0]            word;
    logic                   err;
  } model_req_t;

  task automatic test_random();
    model_req_t mq[$];
    model_req_t h, r;
    logic       exp_v, exp_e;
    logic [31:0] exp_d;
    logic       deq, enq, hv;
    exp_v = 1'b0; exp_e = 1'b0; exp_d = '0;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      @(negedge clk_i);
      hv = (mq.size() > 0) && !mq[0].err;
      checks++; if (cpu_req_ready_o !== (mq.size() < DEPTH) || pipe_req_valid_o !== hv) begin
        failures++; $display("FAIL rnd_flags_%0d: got ready=%b pv=%b want %b/%b", n, cpu_req_ready_o, pipe_req_valid_o, (mq.size() < DEPTH), hv); end
      if (hv) begin
        h = mq[0];
        checks++;
        if (pipe_req_tag_o !== 24'(h.addr >> 8) || pipe_req_set_o !== 3'((h.addr >> 5) % 8) ||
            pipe_req_ofs_o !== 5'(h.addr % 32) || pipe_req_size_o !== h.size ||
            pipe_req_type_o !== h.op || pipe_word_to_store_o !== h.word) begin
          failures++; $display("FAIL rnd_head_%0d: got tag=%h set=%h ofs=%h word=%h want addr=%h word=%h", n, pipe_req_tag_o, pipe_req_set_o, pipe_req_ofs_o, pipe_word_to_store_o, h.addr, h.word); end
      end
      checks++; if (cpu_rsp_valid_o !== exp_v) begin
        failures++; $display("FAIL rnd_rspv_%0d: got %b want %b", n, cpu_rsp_valid_o, exp_v); end
      if (exp_v) begin
        checks++; if (cpu_rsp_error_o !== exp_e || cpu_rsp_data_o !== exp_d) begin
          failures++; $display("FAIL rnd_rsp_%0d: got e=%b d=%h want %b/%h", n, cpu_rsp_error_o, cpu_rsp_data_o, exp_e, exp_d); end
      end
      // Drive the next cycle and advance the model across the coming edge.
      r.addr = $urandom;
      if ($urandom_range(0, 2) != 0) r.addr = r.addr & 32'hFFFF_FFFC;
      r.size = memory_operation_size_e'(2'($urandom_range(0, 2)));
      r.op   = memory_operation_e'(2'($urandom_range(0, 2)));
      r.word = $urandom;
      r.err  = (r.op != CLFLUSH) && (((r.size == HALF) && (r.addr % 2 == 1)) ||
                                     ((r.size == WORD) && (r.addr % 4 != 0)));
      cpu_req_valid_i     = ($urandom_range(0, 9) < 6);
      cpu_req_address_i   = r.addr;
      cpu_req_size_i      = r.size;
      cpu_req_type_i      = r.op;
      cpu_word_to_store_i = r.word;
      req_done_i          = hv && ($urandom_range(0, 1) == 1);
      pipe_fetched_word_i = $urandom;
      enq = cpu_req_valid_i && (mq.size() < DEPTH);
      deq = (mq.size() > 0) && (mq[0].err || req_done_i);
      exp_v = deq; exp_e = 1'b0; exp_d = '0;
      if (deq) begin
        h = mq.pop_front();
        exp_e = h.err;
        if (!h.err && h.op == LOAD) exp_d = pipe_fetched_word_i;
      end
      if (enq) mq.push_back(r);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_fill_full();
    test_misaligned();
    test_wrap_around();
    test_back_to_back();
    test_ignored_done();
    test_reset_mid();
    test_clflush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
